// File: rtl/core_result_collector.sv
// Collects per-core completion results on strobe falling edges, queues {core_id, result}
// through a round-robin arbiter into a FIFO, and serves the host over valid/ready.
module core_result_collector #(
    parameter  int NUM_CORES  = 4,
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 8,
    localparam int ID_W       = $clog2(NUM_CORES),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_strobe,
    input  logic [NUM_CORES*DATA_W-1:0] core_result,
    input  logic                        clear,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [DATA_W-1:0]           rd_data,
    output logic [ID_W-1:0]             rd_core_id,
    output logic [NUM_CORES-1:0]        done_mask,
    output logic                        all_done,
    output logic                        overflow,
    output logic [CNT_W-1:0]            count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [NUM_CORES-1:0] prev_strobe;
    logic [NUM_CORES-1:0] pending;
    logic [NUM_CORES-1:0] fall;
    logic [NUM_CORES-1:0] grant_clr;
    logic [DATA_W-1:0]    hold [NUM_CORES];
    logic [ID_W-1:0]      rr_ptr;

    logic [DATA_W-1:0]    fifo_data [FIFO_DEPTH];
    logic [ID_W-1:0]      fifo_id   [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    logic                 grant_found;
    logic [ID_W-1:0]      grant_id;
    logic                 push;
    logic                 pop;

    assign fall = prev_strobe & ~core_strobe;

    // Search starts at rr_ptr and wraps, so the most recently served core goes last.
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a default first so no latch is inferred.
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!grant_found && pending[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // Fullness is judged on the start-of-cycle count; a same-cycle pop does not free a slot.
    assign push = grant_found && (count < CNT_W'(FIFO_DEPTH));
    assign pop  = rd_valid && rd_ready;

    always_comb begin
        grant_clr = '0;
        if (push) grant_clr[grant_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            prev_strobe <= '0;
            pending     <= '0;
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            done_mask   <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) hold[i] <= '0;
        end else begin
            prev_strobe <= core_strobe;
            // A fall on an already-pending core is dropped rather than queued.
            pending     <= (pending & ~grant_clr) | (fall & ~pending);
            done_mask   <= done_mask | fall;
            if (|(fall & pending)) overflow <= 1'b1;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_strobe[i] && !pending[i]) hold[i] <= core_result[i*DATA_W +: DATA_W];
            end
            if (push) begin
                rr_ptr <= (grant_id == ID_W'(NUM_CORES - 1)) ? '0 : grant_id + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: FIFO storage is not reset; entries are only visible through count, which is.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= hold[grant_id];
            fifo_id[wr_ptr]   <= grant_id;
        end
    end

    assign rd_valid   = (count != '0);
    assign rd_data    = rd_valid ? fifo_data[rd_ptr] : '0;
    assign rd_core_id = rd_valid ? fifo_id[rd_ptr]   : '0;
    assign all_done   = &done_mask;

endmodule

// File: tb/tb_core_result_collector.sv
// Self-checking bench for core_result_collector: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_core_result_collector;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int D   = 8;
    localparam int IDW = 2;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           clear;
    logic           rd_ready;
    logic [N-1:0]   core_strobe;
    logic [N*W-1:0] core_result;
    logic           rd_valid;
    logic [W-1:0]   rd_data;
    logic [IDW-1:0] rd_core_id;
    logic [N-1:0]   done_mask;
    logic           all_done;
    logic           overflow;
    logic [CW-1:0]  count;

    always #5 clk = ~clk;

    core_result_collector #(.NUM_CORES(N), .DATA_W(W), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_strobe (core_strobe),
        .core_result (core_result),
        .clear       (clear),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_core_id  (rd_core_id),
        .done_mask   (done_mask),
        .all_done    (all_done),
        .overflow    (overflow),
        .count       (count)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: completions become queue entries, the FIFO is a plain queue.
    typedef struct { int id; int data; } entry_t;
    entry_t     m_q[$];
    bit [N-1:0] m_prev, m_pend, m_done;
    bit         m_ovf;
    int         m_hold[N];
    int         m_rr;

    task automatic model_step();
        bit [N-1:0] old_pend;
        int         grant;
        bit         full;
        if (reset || clear) begin
            m_q.delete();
            m_prev = '0; m_pend = '0; m_done = '0; m_ovf = 1'b0; m_rr = 0;
            for (int i = 0; i < N; i++) m_hold[i] = 0;
            return;
        end
        old_pend = m_pend;
        grant    = -1;
        full     = (m_q.size() >= D);
        for (int k = 0; k < N; k++)
            if (grant < 0 && m_pend[(m_rr + k) % N]) grant = (m_rr + k) % N;
        if (m_q.size() != 0 && rd_ready) void'(m_q.pop_front());
        if (grant >= 0 && !full) begin
            m_q.push_back('{grant, m_hold[grant]});
            m_pend[grant] = 1'b0;
            m_rr = (grant + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (m_prev[i] && !core_strobe[i]) begin
                m_done[i] = 1'b1;
                if (old_pend[i]) m_ovf = 1'b1;
                else m_pend[i] = 1'b1;
            end
            if (core_strobe[i] && !old_pend[i]) m_hold[i] = int'(core_result[i*W +: W]);
        end
        m_prev = core_strobe;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare against the model; also log every accepted head.
    int obs_id[$];
    int obs_data[$];

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("rd_valid",   rd_valid,   m_q.size() != 0);
            check("count",      count,      m_q.size());
            check("rd_data",    rd_data,    (m_q.size() != 0) ? m_q[0].data : 0);
            check("rd_core_id", rd_core_id, (m_q.size() != 0) ? m_q[0].id : 0);
            check("done_mask",  done_mask,  m_done);
            check("all_done",   all_done,   &m_done);
            check("overflow",   overflow,   m_ovf);
            if (rd_valid && rd_ready) begin
                obs_id.push_back(int'(rd_core_id));
                obs_data.push_back(int'(rd_data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_res(input int i, input int v);
        core_result[i*W +: W] = W'(v);
    endtask

    // Strobe mask high for hi cycles, then low; returns just after the falling-edge sample.
    task automatic pulse(input logic [N-1:0] mask, input int hi);
        core_strobe = mask;
        tick(hi);
        core_strobe = '0;
        tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        obs_id.delete();
        obs_data.delete();
    endtask

    int found_22;

    initial begin
        reset = 1'b1; clear = 1'b0; rd_ready = 1'b0;
        core_strobe = '0; core_result = '0;
        tick(1);
        cmp_en = 1'b1;
        tick(1);
        check("reset_rd_valid",  rd_valid,   0);
        check("reset_rd_data",   rd_data,    0);
        check("reset_rd_id",     rd_core_id, 0);
        check("reset_done_mask", done_mask,  0);
        check("reset_count",     count,      0);
        reset = 1'b0;
        obs_id.delete(); obs_data.delete();

        // Single completion on core 2
        rd_ready = 1'b1;
        set_res(2, 8'h2A);
        pulse(4'b0100, 3);
        check("single_done_at_E",  done_mask, 4'b0100);
        check("single_count_at_E", count, 0);
        tick(1);
        check("single_valid_E1", rd_valid, 1);
        check("single_id_E1",    rd_core_id, 2);
        check("single_data_E1",  rd_data, 8'h2A);
        tick(4);
        check("single_pops",     obs_id.size(), 1);
        check("single_pop_id",   obs_id[0], 2);
        check("single_pop_data", obs_data[0], 8'h2A);
        check("single_overflow", overflow, 0);
        check("single_done",     done_mask, 4'b0100);

        // Simultaneous completion on all four cores
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < N; i++) set_res(i, 10 * (i + 1));
        pulse(4'hF, 1);
        check("simul_count_E", count, 0);
        for (int j = 1; j <= 4; j++) begin
            tick(1);
            check("simul_count_ramp", count, j);
        end
        check("simul_all_done", all_done, 1);
        rd_ready = 1'b1;
        tick(6);
        rd_ready = 1'b0;
        check("simul_pops", obs_id.size(), 4);
        for (int j = 0; j < 4; j++) begin
            check("simul_order_id",   obs_id[j], j);
            check("simul_order_data", obs_data[j], 10 * (j + 1));
        end

        // Full FIFO: nine completions, eighth fills it, ninth waits
        do_reset();
        rd_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) set_res(i, r * 4 + i + 1);
            pulse(4'hF, 1);
            tick(5);
        end
        check("full_count_8", count, 8);
        set_res(0, 9);
        pulse(4'h1, 1);
        tick(3);
        check("full_count_held", count, 8);
        check("full_no_overflow", overflow, 0);
        rd_ready = 1'b1;
        tick(14);
        rd_ready = 1'b0;
        check("full_pops", obs_id.size(), 9);
        for (int j = 0; j < 9; j++) begin
            check("full_order_id",   obs_id[j], j % 4);
            check("full_order_data", obs_data[j], j + 1);
        end
        check("full_drained", count, 0);

        // Overflow: second completion on a still-pending core is dropped
        do_reset();
        rd_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) set_res(i, 8'h31 + r * 4 + i);
            pulse(4'hF, 1);
            tick(5);
        end
        set_res(1, 8'h11);
        pulse(4'h2, 1);
        tick(2);
        check("ovf_not_yet", overflow, 0);
        set_res(1, 8'h22);
        pulse(4'h2, 1);
        check("ovf_set", overflow, 1);
        rd_ready = 1'b1;
        tick(14);
        rd_ready = 1'b0;
        check("ovf_pops",      obs_id.size(), 9);
        check("ovf_last_id",   obs_id[8], 1);
        check("ovf_last_data", obs_data[8], 8'h11);
        found_22 = 0;
        foreach (obs_data[j]) if (obs_data[j] == 8'h22) found_22++;
        check("ovf_0x22_absent", found_22, 0);
        check("ovf_sticky", overflow, 1);

        // Wrap-around: twenty completions streamed through
        do_reset();
        rd_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) set_res(i, (r * 4 + i) * 7 + 3);
            pulse(4'hF, 1);
            tick(5);
        end
        check("wrap_pops", obs_id.size(), 20);
        for (int j = 0; j < 20; j++) begin
            check("wrap_id",   obs_id[j], j % 4);
            check("wrap_data", obs_data[j], j * 7 + 3);
        end
        check("wrap_count_zero", count, 0);

        // Reset mid-operation
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_res(i, 8'h61 + i);
        pulse(4'h7, 1);
        tick(4);
        check("midrst_count3", count, 3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_valid", rd_valid, 0);
        check("midrst_count", count, 0);
        check("midrst_done",  done_mask, 0);
        check("midrst_ovf",   overflow, 0);
        obs_id.delete(); obs_data.delete();
        rd_ready = 1'b1;
        set_res(3, 8'h5A);
        pulse(4'h8, 2);
        tick(4);
        check("midrst_new_pops", obs_id.size(), 1);
        check("midrst_new_id",   obs_id[0], 3);
        check("midrst_new_data", obs_data[0], 8'h5A);
        check("midrst_new_done", done_mask, 4'b1000);

        // Same with clear, strobe held high across its release
        rd_ready = 1'b0;
        pulse(4'h7, 1);
        tick(4);
        check("midclr_count3", count, 3);
        set_res(3, 8'h77);
        core_strobe = 4'h8;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("midclr_valid", rd_valid, 0);
        check("midclr_count", count, 0);
        check("midclr_done",  done_mask, 0);
        obs_id.delete(); obs_data.delete();
        tick(2);
        core_strobe = '0;
        tick(1);
        rd_ready = 1'b1;
        tick(4);
        check("midclr_new_pops", obs_id.size(), 1);
        check("midclr_new_id",   obs_id[0], 3);
        check("midclr_new_data", obs_data[0], 8'h77);
        check("midclr_new_done", done_mask, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
